// File: rtl/human_track_monitor.sv
// Receive-side decoder for the 16-bit one-hot human-position LED bar.
// Tracks the marker, emits depart/arrive pulses and counts crossings, and flags illegal traffic.
module human_track_monitor #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MOVE_TIMEOUT = 1000,
    parameter int unsigned TO_W         = 11
) (
    input  logic             clk1khz,
    input  logic             rst_n,
    input  logic [15:0]      led,
    input  logic             trip_clr,
    output logic [3:0]       pos,
    output logic             on_left,
    output logic             on_right,
    output logic             moving,
    output logic             fault,
    output logic             dir_right,
    output logic             depart_pulse,
    output logic             arrive_pulse,
    output logic [CNT_W-1:0] crossings,
    output logic             err_onehot,
    output logic             err_jump,
    output logic             err_stall
);

    typedef enum logic [2:0] {StAtLeft, StAtRight, StMoving, StOff, StFault} state_e;

    state_e            state_q, state_d;
    logic [15:0]       led_q, led_p;
    logic [3:0]        pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              dep_q, dep_d, arr_q, arr_d;
    logic [CNT_W-1:0]  cross_q, cross_d;
    logic [TO_W-1:0]   stall_q, stall_d;
    logic              eoh_q, eoh_d, ejmp_q, ejmp_d, estl_q, estl_d;

    logic              q_onehot, p_onehot, changed, step_r, step_l;
    logic [3:0]        q_idx;

    assign q_onehot = (led_q != 16'd0) && ((led_q & (led_q - 16'd1)) == 16'd0);
    assign p_onehot = (led_p != 16'd0) && ((led_p & (led_p - 16'd1)) == 16'd0);
    assign changed  = (led_q != led_p);
    assign step_r   = p_onehot && (led_q == (led_p >> 1));
    assign step_l   = p_onehot && (led_q == (led_p << 1));

    always_comb begin
        q_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (led_q[i]) q_idx = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        dep_d   = 1'b0;
        arr_d   = 1'b0;
        cross_d = cross_q;
        stall_d = stall_q;
        // Clear first so an error detected in the same cycle as trip_clr still sets its flag.
        eoh_d   = trip_clr ? 1'b0 : eoh_q;
        ejmp_d  = trip_clr ? 1'b0 : ejmp_q;
        estl_d  = trip_clr ? 1'b0 : estl_q;

        if (led_q != 16'd0 && !q_onehot) begin
            eoh_d   = 1'b1;
            state_d = StFault;
        end else if (led_q == 16'd0) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StAtLeft: begin
                    if (changed) begin
                        if (step_r) begin
                            state_d = StMoving;
                            dir_d   = 1'b1;
                            dep_d   = 1'b1;
                            pos_d   = q_idx;
                            stall_d = '0;
                        end else begin
                            ejmp_d  = 1'b1;
                            state_d = StFault;
                        end
                    end
                end
                StAtRight: begin
                    if (changed) begin
                        if (step_l) begin
                            state_d = StMoving;
                            dir_d   = 1'b0;
                            dep_d   = 1'b1;
                            pos_d   = q_idx;
                            stall_d = '0;
                        end else begin
                            ejmp_d  = 1'b1;
                            state_d = StFault;
                        end
                    end
                end
                StMoving: begin
                    if (!changed) begin
                        if (stall_q == TO_W'(MOVE_TIMEOUT - 1)) begin
                            estl_d  = 1'b1;
                            state_d = StFault;
                        end else begin
                            stall_d = stall_q + 1'b1;
                        end
                    end else if (dir_q ? step_r : step_l) begin
                        pos_d   = q_idx;
                        stall_d = '0;
                        if ((dir_q && q_idx == 4'd0) || (!dir_q && q_idx == 4'd15)) begin
                            state_d = dir_q ? StAtRight : StAtLeft;
                            arr_d   = 1'b1;
                            if (cross_q != '1) cross_d = cross_q + 1'b1;
                        end
                    end else begin
                        ejmp_d  = 1'b1;
                        state_d = StFault;
                    end
                end
                StOff: begin
                    if (q_idx == 4'd15) begin
                        state_d = StAtLeft;
                        pos_d   = q_idx;
                    end else if (q_idx == 4'd0) begin
                        state_d = StAtRight;
                        pos_d   = q_idx;
                    end else begin
                        ejmp_d  = 1'b1;
                        state_d = StFault;
                    end
                end
                StFault: begin
                    pos_d = q_idx;
                    if (trip_clr) begin
                        if (q_idx == 4'd15)     state_d = StAtLeft;
                        else if (q_idx == 4'd0) state_d = StAtRight;
                    end
                end
                default: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clk1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAtLeft;
            led_q   <= 16'h8000;
            led_p   <= 16'h8000;
            pos_q   <= 4'd15;
            dir_q   <= 1'b1;
            dep_q   <= 1'b0;
            arr_q   <= 1'b0;
            cross_q <= '0;
            stall_q <= '0;
            eoh_q   <= 1'b0;
            ejmp_q  <= 1'b0;
            estl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led;
            led_p   <= led_q;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            dep_q   <= dep_d;
            arr_q   <= arr_d;
            cross_q <= cross_d;
            stall_q <= stall_d;
            eoh_q   <= eoh_d;
            ejmp_q  <= ejmp_d;
            estl_q  <= estl_d;
        end
    end

    assign pos          = pos_q;
    assign on_left      = (state_q == StAtLeft);
    assign on_right     = (state_q == StAtRight);
    assign moving       = (state_q == StMoving);
    assign fault        = (state_q == StFault);
    assign dir_right    = dir_q;
    assign depart_pulse = dep_q;
    assign arrive_pulse = arr_q;
    assign crossings    = cross_q;
    assign err_onehot   = eoh_q;
    assign err_jump     = ejmp_q;
    assign err_stall    = estl_q;

endmodule
